// File: rtl/acc_capture.sv
// Captures {Mx, sequence number, ACC} on each qualified accumulator carry-out
// into a first-word fall-through FIFO, counting events lost to a full FIFO.
module acc_capture #(
  parameter int unsigned DW    = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [DW-1:0] ACC,
  input  logic          CO,
  input  logic          Mx,
  output logic [DW-1:0] dout,
  output logic          mx_out,
  output logic [3:0]    seq,
  output logic          dvalid,
  input  logic          dready,
  output logic          full,
  output logic          empty,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_acc [DEPTH];
  logic          mem_mx  [DEPTH];
  logic [3:0]    mem_seq [DEPTH];

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [3:0]    seq_ctr;

  logic capture, pop, do_push, drop;

  assign capture = ce & CO;
  assign pop     = dvalid & dready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign do_push = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign dvalid = ~empty;

  assign dout   = mem_acc[rptr];
  assign mx_out = mem_mx[rptr];
  assign seq    = mem_seq[rptr];

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem_acc[wptr] <= ACC;
      mem_mx[wptr]  <= Mx;
      mem_seq[wptr] <= seq_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq_ctr  <= '0;
      drop_cnt <= '0;
    end else begin
      if (capture) seq_ctr <= seq_ctr + 4'd1;
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (!do_push && pop) count <= count - CW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_acc_capture.sv
// Directed-vector bench for acc_capture with hand-computed expectations.
module tb_acc_capture;

  localparam int unsigned DW    = 11;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, ce, CO, Mx, dready;
  logic [DW-1:0] ACC;
  logic [DW-1:0] dout;
  logic          mx_out, dvalid, full, empty;
  logic [3:0]    seq;
  logic [7:0]    drop_cnt;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  acc_capture #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .ACC(ACC), .CO(CO), .Mx(Mx),
    .dout(dout), .mx_out(mx_out), .seq(seq), .dvalid(dvalid),
    .dready(dready), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 1'b0; CO = 1'b0; dready = 1'b0; Mx = 1'b0; ACC = '0;
  endtask

  task automatic capture(input logic [DW-1:0] a, input logic m, input logic rdy);
    ce = 1'b1; CO = 1'b1; ACC = a; Mx = m; dready = rdy;
    tick();
    idle();
  endtask

  task automatic pop_one();
    dready = 1'b1;
    tick();
    dready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_head(input string tag, input int unsigned a, input int unsigned m,
                             input int unsigned s);
    check({tag, ".dvalid"}, 32'(dvalid), 32'd1);
    check({tag, ".dout"},   32'(dout),   32'(a));
    check({tag, ".mx"},     32'(mx_out), 32'(m));
    check({tag, ".seq"},    32'(seq),    32'(s));
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2;

    // Reset state
    do_reset();
    check("rst.dvalid", 32'(dvalid), 32'd0);
    check("rst.empty",  32'(empty),  32'd1);
    check("rst.full",   32'(full),   32'd0);
    check("rst.drop",   32'(drop_cnt), 32'd0);

    // Single capture, visible the next cycle
    capture(11'h3F0, 1'b1, 1'b0);
    expect_head("single", 32'h3F0, 1, 0);
    pop_one();
    check("single.empty", 32'(empty), 32'd1);

    // dready with nothing stored has no effect
    pop_one();
    check("noval.empty", 32'(empty), 32'd1);

    // Five captures into DEPTH=4: one drop
    do_reset();
    for (int i = 1; i <= 5; i++) capture(DW'(i), 1'(i), 1'b0);
    check("ovf.full", 32'(full), 32'd1);
    check("ovf.drop", 32'(drop_cnt), 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      expect_head($sformatf("ovf.drain%0d", i), i + 1, (i + 1) & 1, i);
      pop_one();
    end
    check("ovf.empty", 32'(empty), 32'd1);
    // seq_ctr is now 5 (dropped event consumed seq 4)

    // Full with simultaneous push and pop: no drop
    for (int i = 10; i <= 13; i++) capture(DW'(i), 1'b0, 1'b0);
    check("fp.full0", 32'(full), 32'd1);
    capture(DW'(7), 1'b1, 1'b1);
    check("fp.full1", 32'(full), 32'd1);
    check("fp.drop",  32'(drop_cnt), 32'd1);
    expect_head("fp.h0", 11, 0, 6);
    pop_one();
    expect_head("fp.h1", 12, 0, 7);
    pop_one();
    expect_head("fp.h2", 13, 0, 8);
    pop_one();
    expect_head("fp.h3", 7, 1, 9);
    pop_one();
    check("fp.empty", 32'(empty), 32'd1);

    // CO without ce is ignored
    CO = 1'b1; ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (empty !== 1'b1) check("noce.empty", 32'(empty), 32'd1);
    end
    check("noce.empty_end", 32'(empty), 32'd1);
    idle();
    capture(11'h055, 1'b0, 1'b0);
    expect_head("noce.next", 32'h055, 0, 10);
    pop_one();

    // 17 captures each popped at once: seq wraps
    do_reset();
    for (int unsigned i = 0; i < 17; i++) begin
      capture(DW'(i * 3), 1'b0, 1'b0);
      check($sformatf("wrap.seq%0d", i), 32'(seq), i % 16);
      pop_one();
    end
    check("wrap.drop",  32'(drop_cnt), 32'd0);
    check("wrap.empty", 32'(empty), 32'd1);

    // Reset coincident with a capture discards everything
    for (int i = 0; i < 3; i++) capture(DW'(i + 100), 1'b1, 1'b0);
    check("mid.dvalid", 32'(dvalid), 32'd1);
    ce = 1'b1; CO = 1'b1; ACC = 11'h123; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    check("mid.empty", 32'(empty), 32'd1);
    check("mid.drop",  32'(drop_cnt), 32'd0);
    capture(11'h2AA, 1'b1, 1'b0);
    expect_head("mid.next", 32'h2AA, 1, 0);

    // drop_cnt saturation; head stays stable while full
    for (int i = 1; i < 4; i++) capture(DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) capture(DW'(i), 1'b0, 1'b0);
    check("sat.drop", 32'(drop_cnt), 32'd255);
    check("sat.full", 32'(full), 32'd1);
    expect_head("sat.head", 32'h2AA, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/acc_capture.md
ACC_CAPTURE -- requirements
Module: acc_capture

Interface
REQ-001 Parameter DW, default 11: width of the captured accumulator value.
REQ-002 Parameter DEPTH, default 4: capture FIFO depth; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state SHALL change only on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ce  input  1  clock enable of the upstream accumulator; qualifies CO.
REQ-006 ACC  input  DW  upstream accumulator value.
REQ-007 CO  input  1  upstream carry-out, marking a completed accumulation window.
REQ-008 Mx  input  1  upstream flag, captured alongside ACC.
REQ-009 dout  output  DW  ACC value of the head FIFO entry.
REQ-010 mx_out  output  1  Mx value of the head FIFO entry.
REQ-011 seq  output  4  sequence number of the head FIFO entry.
REQ-012 dvalid  output  1  head entry is valid.
REQ-013 dready  input  1  consumer accepts the head entry.
REQ-014 full  output  1  FIFO holds DEPTH entries.
REQ-015 empty  output  1  FIFO holds 0 entries.
REQ-016 drop_cnt  output  8  number of capture events lost to a full FIFO.

Function
REQ-017 Capture event: ce=1 and CO=1 at a rising clk edge; CO with ce=0 SHALL be ignored.
REQ-018 On a capture event the block SHALL push {Mx, seq_ctr, ACC} as sampled at that edge.
REQ-019 seq_ctr SHALL increment by 1 on every capture event, including dropped ones, and wrap 15->0.
REQ-020 Pop: dvalid=1 and dready=1 at a rising edge; the head entry is removed.
REQ-021 dready with dvalid=0 SHALL have no effect.
REQ-022 FIFO is first-word fall-through: dout, mx_out and seq SHALL show the head entry combinationally from storage.
REQ-023 Latency: a push into an empty FIFO at edge k SHALL make dvalid=1 for the cycle after edge k.
REQ-024 dvalid SHALL equal !empty.
REQ-025 empty SHALL equal (count==0); full SHALL equal (count==DEPTH).
REQ-026 Occupancy count SHALL range 0..DEPTH; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Push and pop in the same edge with 0<count<DEPTH: both occur and count is unchanged.
REQ-028 Push while full with a simultaneous pop: both occur, count stays DEPTH and there is no drop.
REQ-029 Push while full without a pop: the entry is discarded and drop_cnt increments.
REQ-030 drop_cnt SHALL saturate at 255.
REQ-031 Push while empty with dready=1: the entry SHALL be stored, not bypassed, because a pop requires dvalid=1 at the edge.
REQ-032 When dvalid=1, dout, mx_out and seq SHALL stay stable until the pop edge.

Reset
REQ-033 When rst_n=0 at a rising edge, count, the pointers, seq_ctr and drop_cnt SHALL become 0.
REQ-034 After that reset edge: dvalid=0, empty=1, full=0, drop_cnt=0.
REQ-035 dout, mx_out and seq are don't-care while empty.
REQ-036 A capture event or pop in the same edge as reset SHALL be ignored.
REQ-037 Reset asserted mid-operation SHALL discard all stored entries.
REQ-038 The first capture after reset SHALL carry seq=0.

Verification
REQ-039 Reset, then one capture with ACC=0x3F0, Mx=1, dready=0: next cycle dvalid=1, dout=0x3F0, mx_out=1, seq=0.
REQ-040 Five captures with ACC=1..5, dready=0, DEPTH=4: full=1, drop_cnt=1; draining yields dout 1,2,3,4 with seq 0,1,2,3.
REQ-041 FIFO full, then capture ACC=7 with dready=1 in the same edge: drop_cnt unchanged, count=4, 7 emerges last.
REQ-042 CO=1 with ce=0 for 10 cycles: empty stays 1 and seq_ctr is unchanged.
REQ-043 17 captures, each popped immediately: seq sequence 0..15 then 0; drop_cnt=0.
REQ-044 3 entries stored, rst_n=0 for one edge coincident with a capture: empty=1, drop_cnt=0; next capture has seq=0.
